// File: rtl/uart_receiver_pkg.sv
// Shared UART definitions: frame geometry, receiver FSM encoding,
// and the parity rule used by both the transmitter and the receiver.
package uart_receiver_pkg;

    localparam int UART_DATA_BITS  = 8;
    localparam int UART_FRAME_BITS = 11;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    // Even parity: the parity bit equals the XOR of the data bits.
    function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// UART receive front end: input synchroniser, bit-time tick counter
// and the mid-bit sampling strobe.
module uart_rx_sampler #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int SYNC_STAGES  = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic data_in,
    input  logic restart,
    output logic rx,
    output logic fall,
    output logic mid
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);

    logic [SYNC_STAGES-1:0] sync;
    logic [CW-1:0]          count;

    // Synchroniser chain, preset to the idle (high) line level.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync <= '1;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], data_in};
        end
    end

    // Bit-time counter, held at zero while the FSM waits for a start edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (restart || count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign rx   = sync[SYNC_STAGES-1];
    // The falling edge is spotted one stage early so that the FSM enters
    // START on the same edge that rx itself goes low.
    assign fall = rx & ~sync[SYNC_STAGES-2];
    assign mid  = (count == HALF);

endmodule

// File: rtl/uart_receiver.sv
// UART receiver: frame FSM, shift register and one-entry holding
// register with parity, framing and overrun reporting.
module uart_receiver
    import uart_receiver_pkg::*;
#(
    parameter int CLKS_PER_BIT = 5208,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      data_in,
    input  logic                      read,
    output logic [UART_DATA_BITS-1:0] data_out,
    output logic                      valid,
    output logic                      hold,
    output logic                      parity_error,
    output logic                      framing_error,
    output logic                      overrun
);

    state_t                    state;
    logic [2:0]                bit_idx;
    logic [UART_DATA_BITS-1:0] shreg;
    logic                      p_bit;
    logic                      rx;
    logic                      fall;
    logic                      mid;
    logic                      restart;
    logic                      done;

    assign restart = (state == IDLE);
    assign done    = (state == STOP) && mid;
    assign hold    = valid;

    uart_rx_sampler #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .SYNC_STAGES  (SYNC_STAGES)
    ) u_sampler (
        .clock   (clock),
        .reset   (reset),
        .data_in (data_in),
        .restart (restart),
        .rx      (rx),
        .fall    (fall),
        .mid     (mid)
    );

    // Frame sequencer: walks start, data, parity and stop bits at each mid-sample.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            bit_idx <= '0;
            shreg   <= '0;
            p_bit   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (fall) begin
                        state <= START;
                    end
                end
                START: begin
                    if (mid) begin
                        if (rx) begin
                            state <= IDLE;
                        end else begin
                            state   <= DATA;
                            bit_idx <= '0;
                        end
                    end
                end
                DATA: begin
                    if (mid) begin
                        shreg <= {rx, shreg[UART_DATA_BITS-1:1]};
                        if (bit_idx == 3'(UART_DATA_BITS - 1)) begin
                            state <= PARITY;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                end
                PARITY: begin
                    if (mid) begin
                        p_bit <= rx;
                        state <= STOP;
                    end
                end
                STOP: begin
                    if (mid) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Holding register: a same-edge read frees the slot for the new byte.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            data_out      <= '0;
            valid         <= 1'b0;
            parity_error  <= 1'b0;
            framing_error <= 1'b0;
            overrun       <= 1'b0;
        end else if (done && (!valid || read)) begin
            data_out      <= shreg;
            parity_error  <= even_parity(shreg) != p_bit;
            framing_error <= ~rx;
            valid         <= 1'b1;
        end else if (done) begin
            overrun <= 1'b1;
        end else if (read && valid) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver with a fast bit time:
// a vector table of frames plus hand-written corner-case sequences.
module tb_uart_receiver;
    import uart_receiver_pkg::*;

    localparam int CPB = 16;

    logic       clock = 1'b0;
    logic       reset;
    logic       data_in;
    logic       read;
    logic [7:0] data_out;
    logic       valid;
    logic       hold;
    logic       parity_error;
    logic       framing_error;
    logic       overrun;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0] d;
        logic       pflip;
        logic       stopv;
        logic [7:0] exp_d;
        logic       exp_pe;
        logic       exp_fe;
    } vec_t;

    vec_t vecs[8];

    uart_receiver #(
        .CLKS_PER_BIT (CPB),
        .SYNC_STAGES  (2)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .data_in       (data_in),
        .read          (read),
        .data_out      (data_out),
        .valid         (valid),
        .hold          (hold),
        .parity_error  (parity_error),
        .framing_error (framing_error),
        .overrun       (overrun)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic idle(input int n);
        data_in = 1'b1;
        repeat (n) begin
            @(posedge clock);
            @(negedge clock);
        end
    endtask

    task automatic do_read();
        read = 1'b1;
        @(posedge clock);
        @(negedge clock);
        read = 1'b0;
    endtask

    // Drives one frame starting at a negedge; optionally pulses read on
    // the stop-bit mid-sample edge. lat = posedges until valid seen high.
    task automatic send_frame(input logic [7:0] d, input logic pflip,
                              input logic stopv, input logic rd_stop,
                              output int lat);
        logic [10:0] fr;
        int cyc;
        fr  = {stopv, (^d) ^ pflip, d, 1'b0};
        lat = -1;
        cyc = 0;
        for (int b = 0; b < UART_FRAME_BITS; b++) begin
            data_in = fr[b];
            for (int j = 0; j < CPB; j++) begin
                read = rd_stop && (b == UART_FRAME_BITS - 1) && (j == 10);
                @(posedge clock);
                cyc++;
                @(negedge clock);
                if (lat < 0 && valid) lat = cyc;
            end
        end
        read = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        data_in = 1'b1;
        read = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        idle(10);
    endtask

    initial begin
        int lat;
        int rises;
        logic pv;

        vecs[0] = '{8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
        vecs[1] = '{8'h3C, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b0};
        vecs[2] = '{8'h01, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0};
        vecs[3] = '{8'h5A, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b0};
        vecs[4] = '{8'hFF, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1};
        vecs[5] = '{8'h81, 1'b0, 1'b1, 8'h81, 1'b0, 1'b0};
        vecs[6] = '{8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
        vecs[7] = '{8'hC3, 1'b1, 1'b0, 8'hC3, 1'b1, 1'b1};

        reset = 1'b0;
        data_in = 1'b1;
        read = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst valid", 32'(valid), 32'd0);
        chk("rst data", 32'(data_out), 32'h00);
        chk("rst hold", 32'(hold), 32'd0);
        chk("rst flags", 32'({parity_error, framing_error, overrun}), 32'd0);
        chk("rst state", 32'(dut.state), 32'(IDLE));
        reset = 1'b1;
        idle(10);

        // read while empty is ignored
        do_read();
        chk("read empty", 32'(valid), 32'd0);

        for (int i = 0; i < 8; i++) begin
            send_frame(vecs[i].d, vecs[i].pflip, vecs[i].stopv, 1'b0, lat);
            if (i == 0) begin
                chk("latency ok", 32'(lat >= 10 * CPB + CPB / 2 + 1 &&
                                      lat <= 10 * CPB + CPB / 2 + 3), 32'd1);
            end
            idle(8);
            chk($sformatf("v%0d valid", i), 32'(valid), 32'd1);
            chk($sformatf("v%0d hold", i), 32'(hold), 32'd1);
            chk($sformatf("v%0d data", i), 32'(data_out), 32'(vecs[i].exp_d));
            chk($sformatf("v%0d perr", i), 32'(parity_error), 32'(vecs[i].exp_pe));
            chk($sformatf("v%0d ferr", i), 32'(framing_error), 32'(vecs[i].exp_fe));
            chk($sformatf("v%0d ovr", i), 32'(overrun), 32'd0);
            do_read();
            chk($sformatf("v%0d cleared", i), 32'(valid), 32'd0);
            chk($sformatf("v%0d held", i), 32'(data_out), 32'(vecs[i].exp_d));
        end

        // short low glitch on an idle line
        data_in = 1'b0;
        repeat (5) begin
            @(posedge clock);
            @(negedge clock);
        end
        idle(40);
        chk("glitch valid", 32'(valid), 32'd0);
        chk("glitch state", 32'(dut.state), 32'(IDLE));
        send_frame(8'h5A, 1'b0, 1'b1, 1'b0, lat);
        idle(8);
        chk("post glitch data", 32'(data_out), 32'h5A);
        chk("post glitch valid", 32'(valid), 32'd1);
        do_read();

        // back-to-back without read -> overrun, first byte kept
        do_reset();
        send_frame(8'h11, 1'b0, 1'b1, 1'b0, lat);
        send_frame(8'h22, 1'b0, 1'b1, 1'b0, lat);
        idle(8);
        chk("ovr data", 32'(data_out), 32'h11);
        chk("ovr flag", 32'(overrun), 32'd1);
        chk("ovr valid", 32'(valid), 32'd1);
        do_read();
        chk("ovr sticky", 32'(overrun), 32'd1);

        // read on the stop-mid edge of frame 2 -> new byte, no overrun
        do_reset();
        send_frame(8'h11, 1'b0, 1'b1, 1'b0, lat);
        send_frame(8'h22, 1'b0, 1'b1, 1'b1, lat);
        idle(8);
        chk("rdw data", 32'(data_out), 32'h22);
        chk("rdw ovr", 32'(overrun), 32'd0);
        chk("rdw valid", 32'(valid), 32'd1);
        do_read();

        // line held low for 30 bit times -> exactly one framing-error frame
        rises = 0;
        pv = valid;
        data_in = 1'b0;
        for (int k = 0; k < 30 * CPB; k++) begin
            @(posedge clock);
            @(negedge clock);
            if (valid && !pv) rises++;
            pv = valid;
        end
        chk("break frames", 32'(rises), 32'd1);
        chk("break data", 32'(data_out), 32'h00);
        chk("break ferr", 32'(framing_error), 32'd1);
        chk("break perr", 32'(parity_error), 32'd0);
        idle(20);
        chk("break idle", 32'(dut.state), 32'(IDLE));
        do_read();

        // reset during bit 4 of a frame
        send_frame(8'h3C, 1'b1, 1'b1, 1'b0, lat);
        idle(4);
        chk("pre-rst valid", 32'(valid), 32'd1);
        data_in = 1'b0;
        repeat (CPB) @(negedge clock);
        for (int b = 0; b < 4; b++) begin
            data_in = b[0];
            repeat (CPB) @(negedge clock);
        end
        data_in = 1'b0;
        repeat (CPB / 2) @(negedge clock);
        reset = 1'b0;
        #1;
        chk("mid-rst valid", 32'(valid), 32'd0);
        chk("mid-rst data", 32'(data_out), 32'h00);
        chk("mid-rst hold", 32'(hold), 32'd0);
        chk("mid-rst flags", 32'({parity_error, framing_error, overrun}), 32'd0);
        chk("mid-rst state", 32'(dut.state), 32'(IDLE));
        data_in = 1'b1;
        @(negedge clock);
        reset = 1'b1;
        idle(10);
        send_frame(8'h81, 1'b0, 1'b1, 1'b0, lat);
        idle(8);
        chk("post-rst data", 32'(data_out), 32'h81);
        chk("post-rst valid", 32'(valid), 32'd1);
        chk("post-rst perr", 32'(parity_error), 32'd0);
        chk("post-rst ferr", 32'(framing_error), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
